// File: rtl/bus_control.sv
// CPU address decoder and DTAC generator for the Konami-2 CPU board.
// Optional macro BUSCTL_RMRD_EN enables the tile-chip ROM-readback (rmrd) decode override.
module bus_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        as_n,
    input  logic        bk4,
    input  logic        init_n,
    input  logic [15:0] addr,
    input  logic        woco,
    input  logic        rmrd,
    input  logic        ce,
    input  logic        cq,
    input  logic        rwb,
    output logic        prog_n,
    output logic        bank_n,
    output logic        work_n,
    output logic        cramcs_n,
    output logic        vramcs_n,
    output logic        objcs_n,
    output logic        iocs_n,
    output logic        dtac_n
);

    logic rmrd_eff;
    logic unused_ok;

`ifdef BUSCTL_RMRD_EN
    assign rmrd_eff  = rmrd;
    assign unused_ok = rwb;
`else
    assign rmrd_eff  = 1'b0;
    assign unused_ok = rwb ^ rmrd;
`endif

    logic prog_hit, bank_hit, work_hit, cram_hit, vram_hit, obj_hit, io_hit;
    logic prog_sel, bank_sel, work_sel, cram_sel, vram_sel, obj_sel, io_sel;
    logic fast_sel, vid_sel;
    logic cq_d, vid_q, fast_q;
    logic cq_rise, ack;

    // Raw region decode, independent of strobe and init gating.
    always_comb begin
        prog_hit = 1'b0;
        bank_hit = 1'b0;
        work_hit = 1'b0;
        cram_hit = 1'b0;
        vram_hit = 1'b0;
        obj_hit  = 1'b0;
        io_hit   = 1'b0;
        if (addr[15]) begin
            prog_hit = 1'b1;
        end else if (addr[14]) begin
            if (addr[15:4] == 12'h5F8) begin
                io_hit = 1'b1;
            end else if (!rmrd_eff &&
                         ((addr[15:10] == 6'b011111) || (addr[15:3] == 13'h0F00))) begin
                obj_hit = 1'b1;
            end else begin
                vram_hit = 1'b1;
            end
        end else if (addr[13]) begin
            if (bk4) bank_hit = 1'b1;
            else     prog_hit = 1'b1;
        end else if (addr[12:10] != 3'b000) begin
            work_hit = 1'b1;
        end else if (woco) begin
            cram_hit = 1'b1;
        end else begin
            work_hit = 1'b1;
        end
    end

    // Program ROM keeps decoding during board init so the CPU can boot.
    always_comb begin
        prog_sel = ~as_n & prog_hit;
        bank_sel = ~as_n & init_n & bank_hit;
        work_sel = ~as_n & init_n & work_hit;
        cram_sel = ~as_n & init_n & cram_hit;
        vram_sel = ~as_n & init_n & vram_hit;
        obj_sel  = ~as_n & init_n & obj_hit;
        io_sel   = ~as_n & init_n & io_hit;
        fast_sel = prog_sel | bank_sel | work_sel | cram_sel | io_sel;
        vid_sel  = vram_sel | obj_sel;
    end

    always_comb begin
        prog_n   = ~prog_sel;
        bank_n   = ~bank_sel;
        work_n   = ~work_sel;
        cramcs_n = ~cram_sel;
        vramcs_n = ~vram_sel;
        objcs_n  = ~obj_sel;
        iocs_n   = ~io_sel;
    end

    always_comb begin
        cq_rise = cq & ~cq_d;
        ack     = ~fast_q | (~vid_q & vid_sel & ce & cq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cq_d   <= 1'b0;
            vid_q  <= 1'b1;
            fast_q <= 1'b1;
            dtac_n <= 1'b1;
        end else begin
            cq_d <= cq;
            if (as_n) begin
                vid_q  <= 1'b1;
                fast_q <= 1'b1;
                dtac_n <= 1'b1;
            end else begin
                fast_q <= ~fast_sel;
                if (cq_rise) vid_q <= ~vid_sel;
                // Sticky until the strobe is released.
                if (ack) dtac_n <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_control.sv
// Self-checking bench for bus_control: scoreboard of expected selects and DTAC timing per access.
module tb_bus_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        as_n;
    logic        bk4;
    logic        init_n;
    logic [15:0] addr;
    logic        woco;
    logic        rmrd;
    logic        ce;
    logic        cq;
    logic        rwb;
    logic        prog_n, bank_n, work_n, cramcs_n, vramcs_n, objcs_n, iocs_n, dtac_n;

    bus_control dut (
        .clk      (clk),
        .rst      (rst),
        .as_n     (as_n),
        .bk4      (bk4),
        .init_n   (init_n),
        .addr     (addr),
        .woco     (woco),
        .rmrd     (rmrd),
        .ce       (ce),
        .cq       (cq),
        .rwb      (rwb),
        .prog_n   (prog_n),
        .bank_n   (bank_n),
        .work_n   (work_n),
        .cramcs_n (cramcs_n),
        .vramcs_n (vramcs_n),
        .objcs_n  (objcs_n),
        .iocs_n   (iocs_n),
        .dtac_n   (dtac_n)
    );

    always #5 clk = ~clk;

    // Select vector order: prog, bank, work, cram, vram, obj, io (active-low).
    localparam logic [6:0] SelNone = 7'b1111111;
    localparam logic [6:0] SelProg = 7'b0111111;
    localparam logic [6:0] SelBank = 7'b1011111;
    localparam logic [6:0] SelWork = 7'b1101111;
    localparam logic [6:0] SelCram = 7'b1110111;
    localparam logic [6:0] SelVram = 7'b1111011;
    localparam logic [6:0] SelObj  = 7'b1111101;
    localparam logic [6:0] SelIo   = 7'b1111110;

    localparam int KindFast = 0;
    localparam int KindVid  = 1;
    localparam int KindNone = 2;

    typedef struct {
        string      tag;
        logic [6:0] sel;
        int         kind;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [6:0] sel_vec;
    assign sel_vec = {prog_n, bank_n, work_n, cramcs_n, vramcs_n, objcs_n, iocs_n};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic access(input string tag, input logic [15:0] a, input logic w,
                          input logic b, input logic i, input logic r,
                          input logic [6:0] exp_sel, input int kind);
        exp_t e;
        int   lat;
        @(negedge clk);
        addr   = a;
        woco   = w;
        bk4    = b;
        init_n = i;
        rmrd   = r;
        cq     = 1'b0;
        ce     = 1'b0;
        as_n   = 1'b0;
        sb_q.push_back('{tag, exp_sel, kind});
        #1;
        e = sb_q.pop_front();
        check({e.tag, "_sel"}, {25'd0, sel_vec}, {25'd0, e.sel});
        if (e.kind == KindFast) begin
            @(posedge clk); #1;
            check({e.tag, "_dtac_1clk"}, {31'd0, dtac_n}, 32'd1);
            @(posedge clk); #1;
            check({e.tag, "_dtac_2clk"}, {31'd0, dtac_n}, 32'd0);
        end else if (e.kind == KindVid) begin
            repeat (3) @(posedge clk);
            #1;
            check({e.tag, "_dtac_wait_cq"}, {31'd0, dtac_n}, 32'd1);
            @(negedge clk);
            cq  = 1'b1;
            ce  = 1'b1;
            lat = 0;
            while (lat < 4 && dtac_n) begin
                @(posedge clk); #1;
                lat++;
            end
            check({e.tag, "_dtac_vid_lat"}, lat, 32'd2);
        end else begin
            repeat (3) @(posedge clk);
            #1;
            check({e.tag, "_dtac_none"}, {31'd0, dtac_n}, 32'd1);
        end
        @(negedge clk);
        as_n = 1'b1;
        cq   = 1'b0;
        ce   = 1'b0;
        #1;
        check({e.tag, "_rel_sel"}, {25'd0, sel_vec}, {25'd0, SelNone});
        @(posedge clk); #1;
        check({e.tag, "_rel_dtac"}, {31'd0, dtac_n}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] rmrd_exp;
`ifdef BUSCTL_RMRD_EN
        rmrd_exp = SelVram;
`else
        rmrd_exp = SelObj;
`endif
        rst = 1'b1; as_n = 1'b1; bk4 = 1'b0; init_n = 1'b1; addr = 16'h0000;
        woco = 1'b0; rmrd = 1'b0; ce = 1'b0; cq = 1'b0; rwb = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sel", {25'd0, sel_vec}, {25'd0, SelNone});
        check("rst_dtac", {31'd0, dtac_n}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        access("prog8000",  16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, SelProg, KindFast);
        access("cram0100",  16'h0100, 1'b1, 1'b0, 1'b1, 1'b0, SelCram, KindFast);
        access("work0100",  16'h0100, 1'b0, 1'b0, 1'b1, 1'b0, SelWork, KindFast);
        access("work1fff",  16'h1FFF, 1'b1, 1'b0, 1'b1, 1'b0, SelWork, KindFast);
        access("bank2000",  16'h2000, 1'b0, 1'b1, 1'b1, 1'b0, SelBank, KindFast);
        access("prog2000",  16'h2000, 1'b0, 1'b0, 1'b1, 1'b0, SelProg, KindFast);
        access("io5f80",    16'h5F80, 1'b0, 1'b0, 1'b1, 1'b0, SelIo,   KindFast);
        access("io5f8f",    16'h5F8F, 1'b0, 1'b0, 1'b1, 1'b0, SelIo,   KindFast);
        access("vram5f90",  16'h5F90, 1'b0, 1'b0, 1'b1, 1'b0, SelVram, KindVid);
        access("obj7c10",   16'h7C10, 1'b0, 1'b0, 1'b1, 1'b0, SelObj,  KindVid);
        access("obj7807",   16'h7807, 1'b0, 1'b0, 1'b1, 1'b0, SelObj,  KindVid);
        access("vram7808",  16'h7808, 1'b0, 1'b0, 1'b1, 1'b0, SelVram, KindVid);
        access("rmrd7c10",  16'h7C10, 1'b0, 1'b0, 1'b1, 1'b1, rmrd_exp, KindVid);
        access("vram4800",  16'h4800, 1'b0, 1'b0, 1'b1, 1'b0, SelVram, KindVid);
        access("init0500",  16'h0500, 1'b0, 1'b0, 1'b0, 1'b0, SelNone, KindNone);
        access("init03ff",  16'h03FF, 1'b1, 1'b0, 1'b0, 1'b0, SelNone, KindNone);
        access("initfffe",  16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, SelProg, KindFast);

        // Address change under a held strobe, then reset mid-access.
        @(negedge clk);
        addr = 16'h8000; init_n = 1'b1; woco = 1'b0; as_n = 1'b0;
        sb_q.push_back('{"hold", SelWork, KindFast});
        repeat (2) @(posedge clk);
        #1;
        check("hold_dtac_on", {31'd0, dtac_n}, 32'd0);
        @(negedge clk);
        addr = 16'h0500;
        #1;
        begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.tag, "_sel"}, {25'd0, sel_vec}, {25'd0, e.sel});
        end
        @(posedge clk); #1;
        check("hold_dtac_sticky", {31'd0, dtac_n}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_dtac", {31'd0, dtac_n}, 32'd1);
        @(negedge clk);
        rst  = 1'b0;
        as_n = 1'b1;
        @(posedge clk); #1;
        check("end_dtac", {31'd0, dtac_n}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
